mon_chain_reader: RTL

Reader for a daisy-chained bank of CIC monitor channels. Generates the periodic `samp` strobe that latches every channel's second-order integrator into the shift chain, then clocks the chain tail in over the next `nch` cycles. For each word it applies the matching second-order comb, y = x − 2·x[−1] + x[−2], modulo 2^rwi. It presents one decimated result per channel, tagged with its channel index, on a valid/ready output.

---
 rtl/mon_chain_reader.sv | 128 ++++++++++++
 1 files changed

// File: rtl/mon_chain_reader.sv
// Strobes a daisy-chained CIC monitor bank, shifts the chain tail in and applies the per-channel
// second-order comb; optional saturating drop counter under MON_READER_DROPCNT_EN.
module mon_chain_reader #(
   parameter int rwi = 28,
   parameter int nch = 8,
   parameter int cwi = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic [15:0]           period,
   output logic                  samp,
   input  logic signed [rwi-1:0] chain_in,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic signed [rwi-1:0] out_data,
   output logic [cwi-1:0]        out_chan,
   output logic [15:0]           drop_cnt
);
   localparam logic [15:0]  min_period = 16'(nch + 2);
   localparam logic [cwi:0] nch_w      = (cwi + 1)'(nch);
   localparam logic [cwi:0] cap_last   = (cwi + 1)'(1);

   logic [15:0]           cnt;
   logic [15:0]           eff_period;
   logic                  opp;
   logic [cwi:0]          cap_left;
   logic [1:0]            frm_cnt;
   logic signed [rwi-1:0] x_dat;
   logic [cwi-1:0]        x_chan;
   logic                  x_vld;
   logic                  x_prm;
   logic [rwi-1:0]        h1 [nch];
   logic [rwi-1:0]        h2 [nch];
   logic [rwi-1:0]        y;
   logic                  y_vld;
   logic                  load;

   assign eff_period = (period > min_period) ? period : min_period;
   assign opp        = (cnt == 16'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt  <= 16'd0;
         samp <= 1'b0;
      end else begin
         samp <= en && opp;
         if (en) cnt <= opp ? (eff_period - 16'd1) : (cnt - 16'd1);
      end
   end

   // capture tags each word with its channel and whether its frame is past priming
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cap_left <= '0;
         frm_cnt  <= 2'd0;
         x_vld    <= 1'b0;
         x_prm    <= 1'b0;
         x_dat    <= '0;
         x_chan   <= '0;
      end else begin
         x_vld <= 1'b0;
         if (samp) begin
            cap_left <= nch_w;
         end else if (cap_left != '0) begin
            cap_left <= cap_left - 1'b1;
            x_vld    <= 1'b1;
            x_dat    <= chain_in;
            x_chan   <= cwi'(cap_left - 1'b1);
            x_prm    <= (frm_cnt == 2'd2);
         end
         if (!en && opp)
            frm_cnt <= 2'd0;
         else if (!samp && cap_left == cap_last && frm_cnt != 2'd2)
            frm_cnt <= frm_cnt + 2'd1;
      end
   end

   always_comb y = x_dat - (h1[0] << 1) + h2[0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < nch; i++) begin
            h1[i] <= '0;
            h2[i] <= '0;
         end
      end else if (x_vld) begin
         for (int i = 0; i < nch - 1; i++) begin
            h1[i] <= h1[i+1];
            h2[i] <= h2[i+1];
         end
         h1[nch-1] <= x_dat;
         h2[nch-1] <= h1[0];
      end
   end

   assign y_vld = x_vld && x_prm;
   assign load  = y_vld && (!out_valid || out_ready);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_chan  <= '0;
      end else if (load) begin
         out_valid <= 1'b1;
         out_data  <= y;
         out_chan  <= x_chan;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef MON_READER_DROPCNT_EN
   logic drop;
   assign drop = y_vld && out_valid && !out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         drop_cnt <= 16'd0;
      else if (drop && drop_cnt != 16'hFFFF)
         drop_cnt <= drop_cnt + 16'd1;
   end
`else
   assign drop_cnt = 16'd0;
`endif

endmodule
